// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that funnels NB_REQ simple request ports onto one APB master.
// One transfer in flight: IDLE -> SETUP -> ACCESS -> RESP, with an optional ACCESS timeout.
module apb_req_arbiter #(
    parameter int NB_REQ         = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NB_REQ-1:0]                        req_i,
    input  logic [NB_REQ-1:0]                        we_i,
    input  logic [NB_REQ-1:0][APB_ADDR_WIDTH-1:0]    addr_i,
    input  logic [NB_REQ-1:0][APB_DATA_WIDTH-1:0]    wdata_i,
    output logic [NB_REQ-1:0]                        gnt_o,
    output logic [NB_REQ-1:0]                        rvalid_o,
    output logic [APB_DATA_WIDTH-1:0]                rdata_o,
    output logic                                     err_o,
    output logic                                     psel_o,
    output logic                                     penable_o,
    output logic                                     pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]                paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]                prdata_i,
    input  logic                                     pready_i,
    input  logic                                     pslverr_i
);
    localparam int PW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam logic [APB_DATA_WIDTH-1:0] ABORT_DATA = APB_DATA_WIDTH'(32'hDEADBEEF);
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                    state_q, state_d;
    logic [PW-1:0]             ptr_q, ptr_d;
    logic [PW-1:0]             owner_q, owner_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic [15:0]               cnt_q, cnt_d;

    logic [PW-1:0]             win;
    logic [PW-1:0]             cand;
    logic                      found;
    logic                      timeout_hit;
    int                        idx;

    // Search from the pointer upward, wrapping once; the first requester seen wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NB_REQ) idx = idx - NB_REQ;
            cand = PW'(idx);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // The counter holds the number of ACCESS cycles already spent waiting, so the
    // abort lands on the TIMEOUT_CYCLES-th ACCESS cycle.
    assign timeout_hit = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d  = win;
                    ptr_d    = (win == PW'(NB_REQ - 1)) ? '0 : win + 1'b1;
                    pwrite_d = we_i[win];
                    paddr_d  = addr_i[win];
                    pwdata_d = wdata_i[win];
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_i) begin
                    rdata_d = pwrite_q ? '0 : prdata_i;
                    err_d   = pslverr_i;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = ABORT_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    // Grant is masked during reset so a pending request cannot pulse while held in reset.
    for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_onehot
        assign gnt_o[gi]    = (state_q == IDLE) && found && !rst_i && (win == PW'(gi));
        assign rvalid_o[gi] = (state_q == RESP) && (owner_q == PW'(gi));
    end

    assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o = (state_q == ACCESS);
    assign pwrite_o  = pwrite_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter NB_REQ, default 4, is the number of requesters (2..16).
REQ-002 Parameter APB_ADDR_WIDTH, default 32, is the address width.
REQ-003 Parameter APB_DATA_WIDTH, default 32, is the data width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, is the maximum number of ACCESS cycles without pready (range 0..65535; 0 disables the timeout).
REQ-005 Port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port req_i, input, NB_REQ bits: per-requester transfer request.
REQ-008 Port we_i, input, NB_REQ bits: per-requester write enable (1 = write).
REQ-009 Port addr_i, input, NB_REQ x APB_ADDR_WIDTH: per-requester address.
REQ-010 Port wdata_i, input, NB_REQ x APB_DATA_WIDTH: per-requester write data.
REQ-011 Port gnt_o, output, NB_REQ bits: one-hot grant pulse.
REQ-012 Port rvalid_o, output, NB_REQ bits: one-hot completion pulse.
REQ-013 Port rdata_o, output, APB_DATA_WIDTH: read data shared by all requesters, valid with rvalid_o.
REQ-014 Port err_o, output, 1 bit: error flag shared by all requesters, valid with rvalid_o.
REQ-015 Port psel_o, output, 1 bit: APB select.
REQ-016 Port penable_o, output, 1 bit: APB enable.
REQ-017 Port pwrite_o, output, 1 bit: APB write.
REQ-018 Port paddr_o, output, APB_ADDR_WIDTH: APB address.
REQ-019 Port pwdata_o, output, APB_DATA_WIDTH: APB write data.
REQ-020 Port prdata_i, input, APB_DATA_WIDTH: APB read data.
REQ-021 Port pready_i, input, 1 bit: APB ready.
REQ-022 Port pslverr_i, input, 1 bit: APB slave error.

Function
REQ-023 The FSM SHALL have four states: IDLE, SETUP, ACCESS and RESP; it holds one transfer at a time.
REQ-024 In IDLE with any req_i bit set, the block SHALL select a winner combinationally, pulse gnt_o[winner] for that cycle, latch we, addr and wdata, and move to SETUP.
REQ-025 Arbitration SHALL be round-robin: search starts at pointer p (0 after reset); after a grant to i, p becomes (i+1) mod NB_REQ.
REQ-026 A requester SHALL hold req_i and its command stable until it is granted; after gnt_o, it may change them freely.
REQ-027 In SETUP, the outputs SHALL be psel_o=1, penable_o=0, with latched paddr_o, pwrite_o and pwdata_o; the next state is always ACCESS.
REQ-028 In ACCESS, the outputs SHALL be psel_o=1 and penable_o=1, and the APB outputs SHALL stay stable until the state is left.
REQ-029 In ACCESS with pready_i=1, the block SHALL latch prdata_i (reads only; writes return 0) and pslverr_i, then move to RESP.
REQ-030 Timeout counter: 16 bits, cleared on entry to ACCESS, incremented each ACCESS cycle with pready_i=0.
REQ-031 If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with pready_i still 0, the block SHALL abort to RESP with err=1 and rdata=32'hDEADBEEF.
REQ-032 If pready_i=1 in the same cycle the timeout would fire, pready_i SHALL win.
REQ-033 In RESP, the block SHALL pulse rvalid_o[winner] for one cycle with rdata_o and err_o, drive psel_o=penable_o=0, and return to IDLE.
REQ-034 Minimum latency SHALL be: grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 (pready=1), rvalid in cycle 3, next grant no earlier than cycle 4.
REQ-035 Outside RESP, rdata_o and err_o SHALL hold their last values; gnt_o and rvalid_o SHALL be 0.
REQ-036 psel_o and penable_o SHALL be 0 in IDLE and RESP.

Reset
REQ-037 While rst_i=1 at a clock edge, the block SHALL set the state to IDLE, p=0, counter=0, all outputs to 0, and rdata_o to 0.
REQ-038 A reset mid-transfer (SETUP/ACCESS/RESP) SHALL abandon the transfer: no rvalid_o pulse, and psel_o=0 from the next cycle.

Verification
REQ-039 Single read: req_i=0001, addr=0x1A10_0004, pready=1 in the first ACCESS cycle, prdata=0x1234_5678 -> gnt c0, psel c1, penable c2, rvalid_o=0001 c3 with rdata 0x1234_5678 and err 0.
REQ-040 All four requesting continuously from reset -> grant order 0,1,2,3,0 with one grant per 4 cycles.
REQ-041 Write with pready low for 3 ACCESS cycles and pslverr=1 -> ACCESS lasts 4 cycles with stable APB outputs, then rvalid with err 1.
REQ-042 TIMEOUT_CYCLES=8 and pready stuck at 0 -> abort after 8 ACCESS cycles with err 1 and rdata 0xDEADBEEF; the next request still proceeds.
REQ-043 rst_i asserted in the second ACCESS cycle -> no rvalid; next cycle psel 0 and gnt 0; after release, requester 0 wins first.
REQ-044 pready_i=1 in the exact timeout cycle -> normal completion with err = pslverr_i and the real prdata.
